// File: rtl/decoder_pkg.sv
// Shared definitions for the 16-bit Thumb category decoder: opcode patterns,
// the category vector layout and the category-to-flag mapping.
package decoder_pkg;

  localparam int OP_W = 6;

  // Wildcard patterns over inst[31:26]; '?' bits are don't-care in casez.
  localparam logic [OP_W-1:0] OP_ARITH  = 6'b00????;
  localparam logic [OP_W-1:0] OP_DP     = 6'b010000;
  localparam logic [OP_W-1:0] OP_SDIBE  = 6'b010001;
  localparam logic [OP_W-1:0] OP_LLP    = 6'b01001?;
  localparam logic [OP_W-1:0] OP_LSSD_A = 6'b0101??;
  localparam logic [OP_W-1:0] OP_LSSD_B = 6'b011???;
  localparam logic [OP_W-1:0] OP_LSSD_C = 6'b100???;
  localparam logic [OP_W-1:0] OP_GPCA   = 6'b10100?;
  localparam logic [OP_W-1:0] OP_GSPA   = 6'b10101?;
  localparam logic [OP_W-1:0] OP_MISC   = 6'b1011??;
  localparam logic [OP_W-1:0] OP_SMR    = 6'b11000?;
  localparam logic [OP_W-1:0] OP_LMR    = 6'b11001?;
  localparam logic [OP_W-1:0] OP_CBSC   = 6'b1101??;
  localparam logic [OP_W-1:0] OP_UCB    = 6'b11100?;

  typedef enum logic [3:0] {
    CAT_NONE,
    CAT_ARITH,
    CAT_DP,
    CAT_SDIBE,
    CAT_LLP,
    CAT_LSSD,
    CAT_GPCA,
    CAT_GSPA,
    CAT_MISC,
    CAT_SMR,
    CAT_LMR,
    CAT_CBSC,
    CAT_UCB
  } cat_e;

  // Field order fixes the packed layout: arith is the MSB, ucb the LSB.
  typedef struct packed {
    logic arith;
    logic dp;
    logic sdibe;
    logic llp;
    logic lssd;
    logic gpca;
    logic gspa;
    logic misc;
    logic smr;
    logic lmr;
    logic cbsc;
    logic ucb;
  } cat_t;

  function automatic cat_t to_onehot(input cat_e c);
    cat_t v;
    v = '0;
    case (c)
      CAT_ARITH: v.arith = 1'b1;
      CAT_DP:    v.dp    = 1'b1;
      CAT_SDIBE: v.sdibe = 1'b1;
      CAT_LLP:   v.llp   = 1'b1;
      CAT_LSSD:  v.lssd  = 1'b1;
      CAT_GPCA:  v.gpca  = 1'b1;
      CAT_GSPA:  v.gspa  = 1'b1;
      CAT_MISC:  v.misc  = 1'b1;
      CAT_SMR:   v.smr   = 1'b1;
      CAT_LMR:   v.lmr   = 1'b1;
      CAT_CBSC:  v.cbsc  = 1'b1;
      CAT_UCB:   v.ucb   = 1'b1;
      default:   v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/decoder_comb.sv
// Combinational classification of a Thumb primary opcode into one category;
// 32-bit prefixes and non-16-bit words yield no category.
module decoder_comb
  import decoder_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic            inst_16,
  output cat_t            cat
);

  cat_e kind;

  always_comb begin
    kind = CAT_NONE;
    if (inst_16) begin
      casez (op)
        OP_ARITH:  kind = CAT_ARITH;
        OP_DP:     kind = CAT_DP;
        OP_SDIBE:  kind = CAT_SDIBE;
        OP_LLP:    kind = CAT_LLP;
        OP_LSSD_A,
        OP_LSSD_B,
        OP_LSSD_C: kind = CAT_LSSD;
        OP_GPCA:   kind = CAT_GPCA;
        OP_GSPA:   kind = CAT_GSPA;
        OP_MISC:   kind = CAT_MISC;
        OP_SMR:    kind = CAT_SMR;
        OP_LMR:    kind = CAT_LMR;
        OP_CBSC:   kind = CAT_CBSC;
        OP_UCB:    kind = CAT_UCB;
        default:   kind = CAT_NONE;
      endcase
    end
  end

  assign cat = to_onehot(kind);

endmodule

// File: rtl/decoder.sv
// Registered 16-bit Thumb category decoder: one-hot flags appear one cycle
// after the instruction, cleared asynchronously by rst.
module decoder
  import decoder_pkg::*;
(
  input  logic [31:0] inst,
  input  logic        inst_16,
  input  logic        clk,
  output logic        arith,
  output logic        dp,
  output logic        sdibe,
  output logic        llp,
  output logic        lssd,
  output logic        gpca,
  output logic        gspa,
  output logic        misc,
  output logic        smr,
  output logic        lmr,
  output logic        cbsc,
  output logic        ucb,
  input  logic        rst
);

  cat_t cat_d;
  cat_t cat_q;

  // Operand bits of the halfword and the low halfword never affect the category.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst[31-OP_W:0];

  decoder_comb u_comb (
    .op      (inst[31 -: OP_W]),
    .inst_16 (inst_16),
    .cat     (cat_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cat_q <= '0;
    else     cat_q <= cat_d;
  end

  assign arith = cat_q.arith;
  assign dp    = cat_q.dp;
  assign sdibe = cat_q.sdibe;
  assign llp   = cat_q.llp;
  assign lssd  = cat_q.lssd;
  assign gpca  = cat_q.gpca;
  assign gspa  = cat_q.gspa;
  assign misc  = cat_q.misc;
  assign smr   = cat_q.smr;
  assign lmr   = cat_q.lmr;
  assign cbsc  = cat_q.cbsc;
  assign ucb   = cat_q.ucb;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: opcode sweeps, randomized instructions,
// latency, operand-bit independence and asynchronous reset behaviour.
module tb_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst = '0;
  logic        inst_16 = 1'b0;
  logic arith, dp, sdibe, llp, lssd, gpca, gspa, misc, smr, lmr, cbsc, ucb;

  int vectors = 0;
  int miscompares = 0;

  decoder dut (
    .inst(inst), .inst_16(inst_16), .clk(clk),
    .arith(arith), .dp(dp), .sdibe(sdibe), .llp(llp), .lssd(lssd),
    .gpca(gpca), .gspa(gspa), .misc(misc), .smr(smr), .lmr(lmr),
    .cbsc(cbsc), .ucb(ucb), .rst(rst)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] flags();
    return {arith, dp, sdibe, llp, lssd, gpca, gspa, misc, smr, lmr, cbsc, ucb};
  endfunction

  // Reference: bit index counted from arith (11) down to ucb (0), by opcode range.
  function automatic logic [11:0] model(input int op, input bit i16);
    logic [11:0] v;
    v = '0;
    if (!i16)                      return v;
    if (op < 16)                   v[11] = 1'b1;
    else if (op == 16)             v[10] = 1'b1;
    else if (op == 17)             v[9]  = 1'b1;
    else if (op <= 19)             v[8]  = 1'b1;
    else if (op <= 39)             v[7]  = 1'b1;
    else if (op <= 41)             v[6]  = 1'b1;
    else if (op <= 43)             v[5]  = 1'b1;
    else if (op <= 47)             v[4]  = 1'b1;
    else if (op <= 49)             v[3]  = 1'b1;
    else if (op <= 51)             v[2]  = 1'b1;
    else if (op <= 55)             v[1]  = 1'b1;
    else if (op <= 57)             v[0]  = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] mk_inst(input int op, input logic [25:0] low);
    logic [5:0] o;
    o = op[5:0];
    return {o, low};
  endfunction

  task automatic apply(input int op, input bit i16, input logic [25:0] low, input string tag);
    logic [11:0] exp_v, got;
    @(negedge clk);
    inst = mk_inst(op, low);
    inst_16 = i16;
    @(posedge clk);
    #1;
    exp_v = model(op, i16);
    got = flags();
    vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL %s op=%0d i16=%0d got=%b exp=%b", tag, op, i16, got, exp_v);
    end
    vectors++;
    if ($countones(got) > 1) begin
      miscompares++;
      $display("FAIL %s_onehot op=%0d got=%b exp=at most one bit", tag, op, got);
    end
  endtask

  task automatic test_reset();
    logic [11:0] got;
    inst = mk_inst(0, '0);
    inst_16 = 1'b1;
    #1 rst = 1'b1;
    #1;
    got = flags();
    vectors++;
    if (got !== 12'b0) begin
      miscompares++;
      $display("FAIL reset_async got=%b exp=%b", got, 12'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    got = flags();
    vectors++;
    if (got !== 12'b1000_0000_0000) begin
      miscompares++;
      $display("FAIL reset_release got=%b exp=%b", got, 12'b1000_0000_0000);
    end
  endtask

  task automatic test_sweep16();
    for (int op = 0; op < 64; op++) apply(op, 1'b1, 26'($urandom), "sweep16");
  endtask

  task automatic test_sweep32();
    for (int op = 0; op < 64; op++) apply(op, 1'b0, 26'($urandom), "sweep32");
  endtask

  task automatic test_low_bits();
    for (int i = 0; i < 20; i++) apply(52, 1'b1, 26'($urandom), "low_bits");
  endtask

  task automatic test_latency();
    logic [11:0] got;
    apply(0, 1'b1, '0, "lat_setup");
    #2 inst = mk_inst(16, '0);
    #1;
    got = flags();
    vectors++;
    if (got !== 12'b1000_0000_0000) begin
      miscompares++;
      $display("FAIL latency_hold got=%b exp=%b", got, 12'b1000_0000_0000);
    end
    @(posedge clk);
    #1;
    got = flags();
    vectors++;
    if (got !== 12'b0100_0000_0000) begin
      miscompares++;
      $display("FAIL latency_update got=%b exp=%b", got, 12'b0100_0000_0000);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] got;
    apply(44, 1'b1, '0, "mid_setup");
    #1 rst = 1'b1;
    #1;
    got = flags();
    vectors++;
    if (got !== 12'b0) begin
      miscompares++;
      $display("FAIL reset_mid_async got=%b exp=%b", got, 12'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    got = flags();
    vectors++;
    if (got !== 12'b0) begin
      miscompares++;
      $display("FAIL reset_mid_hold got=%b exp=%b", got, 12'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    got = flags();
    vectors++;
    if (got !== model(44, 1'b1)) begin
      miscompares++;
      $display("FAIL reset_mid_release got=%b exp=%b", got, model(44, 1'b1));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++)
      apply(int'($urandom_range(63, 0)), bit'($urandom_range(1, 0)), 26'($urandom), "random");
  endtask

  task automatic test_back_to_back();
    int ops[$] = '{0, 16, 17, 18, 20, 40, 42, 44, 48, 50, 52, 56, 58, 63, 15, 39};
    foreach (ops[i]) apply(ops[i], 1'b1, '0, "b2b");
  endtask

  initial begin
    test_reset();
    test_sweep16();
    test_sweep32();
    test_low_bits();
    test_latency();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decoder.md
Name: decoder

Overview:
- Registered category decoder for 16-bit Thumb instructions in the fetch/decode front end.
- The 16-bit halfword is carried in inst[31:16]; its primary opcode field is inst[31:26].
- Produces 12 one-hot category flags, one clock after the instruction is presented. These flags select the downstream detailed sub-decoders.
- When inst_16 is low, the word is a 32-bit instruction and no 16-bit category is flagged.

Parameters:
- None. The opcode field width is fixed at 6 (a package constant, see Decomposition).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- inst  input  32  instruction word; a 16-bit instruction occupies [31:16]; only [31:26] is decoded
- inst_16  input  1  1 = inst holds a 16-bit Thumb instruction
- arith  output  1  shift (immediate), add, subtract, move, compare
- dp  output  1  data processing (register)
- sdibe  output  1  special data instructions and branch/exchange
- llp  output  1  load from literal pool
- lssd  output  1  load/store single data item
- gpca  output  1  generate PC-relative address
- gspa  output  1  generate SP-relative address
- misc  output  1  miscellaneous 16-bit instructions
- smr  output  1  store multiple registers
- lmr  output  1  load multiple registers
- cbsc  output  1  conditional branch and supervisor call
- ucb  output  1  unconditional branch

Declaration order (positional instantiation is used): inst, inst_16, clk, arith, dp, sdibe, llp, lssd, gpca, gspa, misc, smr, lmr, cbsc, ucb, rst.

Behaviour:
- While rst is high, all 12 outputs are 0 immediately, independent of clk.
- On each rising clk edge with rst low, all outputs are registered from a combinational decode of the current inst[31:26] and inst_16. Latency is 1 cycle; no handshake.
- Decode of op = inst[31:26] when inst_16 = 1:
  - 00xxxx -> arith
  - 010000 -> dp
  - 010001 -> sdibe
  - 01001x -> llp
  - 0101xx, 011xxx, 100xxx -> lssd
  - 10100x -> gpca
  - 10101x -> gspa
  - 1011xx -> misc
  - 11000x -> smr
  - 11001x -> lmr
  - 1101xx -> cbsc
  - 11100x -> ucb
  - 11101x, 1111xx (32-bit prefixes) -> all outputs 0
- When inst_16 = 0, all outputs are registered as 0 regardless of op.
- At most one output is high in any cycle (one-hot or all-zero).
- inst[25:0] has no effect.
- Inputs changing mid-cycle have no effect until the next rising edge.
- Reset released mid-stream: the first edge after release registers the current decode.

Decomposition:
- Shared package decoder_pkg holds:
  - localparam OP_W = 6
  - opcode pattern constants (OP_ARITH, OP_DP, OP_SDIBE, ...)
  - a typedef for the 12-bit category vector, ordered {arith, dp, sdibe, llp, lssd, gpca, gspa, misc, smr, lmr, cbsc, ucb}
- One natural sub-module, decoder_comb: purely combinational op + inst_16 -> category vector.
- The top level is the output register with asynchronous reset.

Test Plan:
- Assert rst with inst[31:26] = 000000 and inst_16 = 1 -> all outputs 0 immediately, before any clock edge. Release rst -> arith = 1 after the next edge.
- Sweep inst[31:26] from 0 to 63 with inst_16 = 1, checking 1 ns after each edge:
  - 16 -> dp
  - 17 -> sdibe
  - 18, 19 -> llp
  - 20..39 -> lssd
  - 40, 41 -> gpca
  - 42, 43 -> gspa
  - 44..47 -> misc
  - 48, 49 -> smr
  - 50, 51 -> lmr
  - 52..55 -> cbsc
  - 56, 57 -> ucb
  - 58..63 -> all 0
- Repeat the sweep with inst_16 = 0 -> all outputs 0 for every op.
- Hold op = 110100 and toggle inst[25:0] randomly -> cbsc stays 1 and all others stay 0.
- Change op from 000000 to 010000 between edges -> arith holds until the next rising edge, then dp = 1 and arith = 0 (1-cycle latency).
- Assert rst mid-sweep while op = 101100 (misc = 1) -> misc drops to 0 asynchronously and stays 0 while rst is high.
